// File: rtl/mux_sel_arbiter_if.sv
// Bus between four requesting stages and the round-robin arbiter for one shared mux/port.
// Protocol: req[i] is a level held by requester i; done is a one-cycle pulse from the resource.
interface mux_sel_arbiter_if;
  // gnt/sel/start/busy/timeout_err are registered outputs of the arbiter.
  // A grant lasts from start until the cycle after done or watchdog expiry.
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       start;
  logic       busy;
  logic       timeout_err;
  logic [1:0] state_dbg;
  logic [1:0] ptr_dbg;

  modport master (
    output req, done,
    input  gnt, sel, start, busy, timeout_err, state_dbg, ptr_dbg
  );

  modport slave (
    input  req, done,
    output gnt, sel, start, busy, timeout_err, state_dbg, ptr_dbg
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for a 4:1 mux-fed resource: one grant at a time, start strobe,
// grant held until done or watchdog expiry. TIMEOUT=0 disables the watchdog.
module mux_sel_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5   // must satisfy 2**CNT_W > TIMEOUT
) (
  input  logic               clk,
  input  logic               resetn,
  mux_sel_arbiter_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam bit               WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             terr_q, terr_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] wd_q, wd_d;

  logic       win_valid;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       release_now;

  // Scan from the farthest candidate back to ptr so the nearest requester is assigned last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (bus.req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    terr_d      = 1'b0;
    ptr_d       = ptr_q;
    wd_d        = wd_q;
    release_now = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_ISSUE;
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
          start_d = 1'b1;
          busy_d  = 1'b1;
          wd_d    = '0;
        end
      end
      ST_ISSUE: begin
        if (bus.done) release_now = 1'b1;
        else          state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // done wins over a simultaneous watchdog expiry, so no error pulse then.
        if (bus.done) begin
          release_now = 1'b1;
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          release_now = 1'b1;
          terr_d      = 1'b1;
        end else if (WD_EN) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (release_now) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      busy_d  = 1'b0;
      wd_d    = '0;
      ptr_d   = sel_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      ptr_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.sel         = sel_q;
  assign bus.start       = start_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;
  assign bus.state_dbg   = state_q;
  assign bus.ptr_dbg     = ptr_q;

endmodule
